sram_tile_buf_mn: RTL and testbench

- Parametrised M×N output-tile buffer for the C matrix of the FP32 systolic pipeline.
- Provides a random-access read port (1-cycle latency) and a byte-masked write port, addressed by (row, col) and stored row-major.
- Adds two capabilities over a plain tile buffer:
  - a bulk-clear engine;
  - a row-major drain stream with valid/ready backpressure for unloading a finished tile to the egress path.

---
 rtl/sram_tile_pkg.sv | 9 +
 rtl/sram_tile_buf_mn_skid.sv | 39 +++
 rtl/sram_tile_buf_mn.sv | 131 +++++++++++++
 tb/tb_sram_tile_buf_mn.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_tile_pkg.sv
// sram_tile_pkg: shared state type, conflict-policy codes and addressing helper for the C-tile buffer
package sram_tile_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DRAIN} tile_state_e;
  localparam int POL_OLD = 0;
  localparam int POL_NEW = 1;
  function automatic logic [31:0] lin_addr(input logic [31:0] row, input logic [31:0] col, input logic [31:0] n);
    return row * n + col;
  endfunction
endpackage

// File: rtl/sram_tile_buf_mn_skid.sv
// tile_drain_skid: 2-entry valid/ready skid FIFO holding packed {data,row,col,last} drain words
module tile_drain_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] ent_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] ent_o,
  output logic [1:0]   cnt_o
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic pop;
  assign pop = (cnt_q != 2'd0) && ready_i;
  always_comb begin
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop};
    head_d = (pop && cnt_q == 2'd2) ? tail_q : head_q;
    tail_d = tail_q;
    if (push_i && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) head_d = ent_i;
    else if (push_i) tail_d = ent_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
  assign valid_o = cnt_q != 2'd0;
  assign ent_o   = head_q;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/sram_tile_buf_mn.sv
// sram_tile_buf_mn: M x N C-tile buffer with random-access ports, bulk clear and a row-major drain stream
module sram_tile_buf_mn
  import sram_tile_pkg::*;
#(
  parameter int M               = 8,
  parameter int N               = 8,
  parameter int DATA_W          = 32,
  parameter int BYTE_W          = DATA_W / 8,
  parameter int CONFLICT_POLICY = POL_NEW,
  parameter int ROW_W           = (M <= 1) ? 1 : $clog2(M),
  parameter int COL_W           = (N <= 1) ? 1 : $clog2(N),
  parameter int DEPTH           = M * N,
  parameter int ADDR_W          = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_en,
  input  logic              c_re,
  input  logic [ROW_W-1:0]  c_row,
  input  logic [COL_W-1:0]  c_col,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_rvalid,
  input  logic              c_we_en,
  input  logic              c_we,
  input  logic [ROW_W-1:0]  c_wrow,
  input  logic [COL_W-1:0]  c_wcol,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [BYTE_W-1:0] c_wmask,
  input  logic              clr_start,
  output logic              clr_done,
  input  logic              drn_start,
  output logic              drn_valid,
  input  logic              drn_ready,
  output logic [DATA_W-1:0] drn_data,
  output logic [ROW_W-1:0]  drn_row,
  output logic [COL_W-1:0]  drn_col,
  output logic              drn_last,
  output logic              busy
);
  localparam int EW = DATA_W + ROW_W + COL_W + 1;
  localparam logic [ADDR_W:0] DEP = (ADDR_W + 1)'(DEPTH);
  tile_state_e st_q, st_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] pr_q, pr_d;
  logic [COL_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d, wold, wmerged, rword;
  logic rvalid_q, done_q, done_d;
  logic idle, rd, wr, rd_ok, wr_ok, issue, col_end;
  logic [ADDR_W-1:0] raddr, waddr, paddr;
  logic [1:0] sk_cnt;
  logic [EW-1:0] sk_out;
  assign idle  = st_q == ST_IDLE;
  assign busy  = !idle;
  assign rd_ok = 32'(c_row) < M && 32'(c_col) < N;
  assign wr_ok = 32'(c_wrow) < M && 32'(c_wcol) < N;
  assign raddr = ADDR_W'(lin_addr(32'(c_row), 32'(c_col), N));
  assign waddr = ADDR_W'(lin_addr(32'(c_wrow), 32'(c_wcol), N));
  assign paddr = cnt_q[ADDR_W-1:0];
  assign rd    = idle && c_en && c_re;
  assign wr    = idle && c_we_en && c_we && wr_ok;
  assign wold  = mem_q[waddr];
  for (genvar i = 0; i < BYTE_W; i++) begin : g_b
    assign wmerged[i*8 +: 8] = c_wmask[i] ? c_wdata[i*8 +: 8] : wold[i*8 +: 8];
  end
  // policy NEW forwards the mask-merged write word to a same-address read
  assign rword   = (wr && waddr == raddr && CONFLICT_POLICY != POL_OLD) ? wmerged : mem_q[raddr];
  assign rdata_d = rd ? (rd_ok ? rword : '0) : rdata_q;
  assign col_end = 32'(pc_q) == N - 1;
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    pr_d   = pr_q;
    pc_d   = pc_q;
    done_d = 1'b0;
    issue  = 1'b0;
    if (st_q == ST_IDLE) begin
      st_d  = clr_start ? ST_CLEAR : drn_start ? ST_DRAIN : ST_IDLE;
      cnt_d = '0;
      pr_d  = '0;
      pc_d  = '0;
    end else if (st_q == ST_CLEAR) begin
      cnt_d  = cnt_q + 1'b1;
      done_d = cnt_d == DEP;
      st_d   = done_d ? ST_IDLE : ST_CLEAR;
    end else begin
      issue = cnt_q < DEP && sk_cnt < 2'd2;
      cnt_d = issue ? cnt_q + 1'b1 : cnt_q;
      pc_d  = issue ? (col_end ? '0 : pc_q + 1'b1) : pc_q;
      pr_d  = (issue && col_end) ? pr_q + 1'b1 : pr_q;
      st_d  = (drn_valid && drn_ready && drn_last) ? ST_IDLE : ST_DRAIN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      cnt_q    <= '0;
      pr_q     <= '0;
      pc_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      pr_q     <= pr_d;
      pc_q     <= pc_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rd;
      done_q   <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (st_q == ST_CLEAR) mem_q[paddr] <= '0;
    else if (wr) mem_q[waddr] <= wmerged;
  end
  tile_drain_skid #(.W(EW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (issue),
    .ent_i   ({mem_q[paddr], pr_q, pc_q, 32'(pr_q) == M - 1 && col_end}),
    .ready_i (drn_ready),
    .valid_o (drn_valid),
    .ent_o   (sk_out),
    .cnt_o   (sk_cnt)
  );
  assign {drn_data, drn_row, drn_col, drn_last} = sk_out;
  assign c_rdata  = rdata_q;
  assign c_rvalid = rvalid_q;
  assign clr_done = done_q;
endmodule

// File: tb/tb_sram_tile_buf_mn.sv
// tb_sram_tile_buf_mn: scoreboard bench driving a POLICY=0 and a POLICY=1 instance with identical stimulus
module tb_sram_tile_buf_mn;
  typedef struct packed {logic [31:0] d; logic [31:0] cyc;} rexp_t;
  typedef struct packed {logic [31:0] d; logic [1:0] r; logic [1:0] c; logic l;} dexp_t;
  logic clk = 0, rst_n;
  logic c_en, c_re, c_we_en, c_we, clr_start, drn_start, drn_ready;
  logic [1:0] c_row, c_col, c_wrow, c_wcol;
  logic [31:0] c_wdata;
  logic [3:0] c_wmask;
  logic [31:0] rdata [2], drn_data [2];
  logic rvalid [2], clr_done [2], drn_valid [2], drn_last [2], busy [2];
  logic [1:0] drn_row [2], drn_col [2];
  rexp_t rq [2][$];
  dexp_t dq [2][$];
  int nbeat [2];
  logic held [2], plast [2];
  dexp_t hv [2];
  logic [31:0] mdl [16];
  int ntests = 0, nfail = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_u
    sram_tile_buf_mn #(.M(4), .N(4), .DATA_W(32), .CONFLICT_POLICY(g)) u (
      .clk(clk), .rst_n(rst_n), .c_en(c_en), .c_re(c_re), .c_row(c_row), .c_col(c_col),
      .c_rdata(rdata[g]), .c_rvalid(rvalid[g]), .c_we_en(c_we_en), .c_we(c_we),
      .c_wrow(c_wrow), .c_wcol(c_wcol), .c_wdata(c_wdata), .c_wmask(c_wmask),
      .clr_start(clr_start), .clr_done(clr_done[g]), .drn_start(drn_start),
      .drn_valid(drn_valid[g]), .drn_ready(drn_ready), .drn_data(drn_data[g]),
      .drn_row(drn_row[g]), .drn_col(drn_col[g]), .drn_last(drn_last[g]), .busy(busy[g])
    );
    initial begin
      nbeat[g] = 0;
      held[g] = 0;
      plast[g] = 0;
    end
    always @(posedge clk) begin
      rexp_t e;
      #1;
      if (rvalid[g]) begin
        if (rq[g].size() == 0) chk(g ? "u1 spurious rvalid" : "u0 spurious rvalid", 1, 0);
        else begin
          e = rq[g].pop_front();
          chk(g ? "u1 rdata" : "u0 rdata", rdata[g], e.d);
          chk(g ? "u1 read latency" : "u0 read latency", cyc, e.cyc);
        end
      end
    end
    always @(negedge clk) begin
      dexp_t e, cur;
      #1;
      cur = {drn_data[g], drn_row[g], drn_col[g], drn_last[g]};
      if (held[g]) chk(g ? "u1 drain stall stable" : "u0 drain stall stable", {drn_valid[g], cur}, {1'b1, hv[g]});
      if (plast[g]) chk(g ? "u1 busy after last" : "u0 busy after last", busy[g], 0);
      held[g] = drn_valid[g] && !drn_ready;
      hv[g] = cur;
      plast[g] = drn_valid[g] && drn_ready && drn_last[g];
      if (drn_valid[g] && drn_ready) begin
        nbeat[g]++;
        if (dq[g].size() == 0) chk(g ? "u1 extra drain beat" : "u0 extra drain beat", 1, 0);
        else begin
          e = dq[g].pop_front();
          chk(g ? "u1 drain beat" : "u0 drain beat", cur, e);
        end
      end
    end
  end
  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    for (int b = 0; b < 4; b++) if (m[b]) o[b*8 +: 8] = n[b*8 +: 8];
    return o;
  endfunction
  task automatic step();
    @(negedge clk);
    c_en = 0; c_re = 0; c_we_en = 0; c_we = 0; clr_start = 0; drn_start = 0;
  endtask
  task automatic wr(input int r, input int c, input logic [31:0] d, input logic [3:0] m);
    step();
    c_we_en = 1; c_we = 1; c_wrow = 2'(r); c_wcol = 2'(c); c_wdata = d; c_wmask = m;
    mdl[r*4+c] = mrg(mdl[r*4+c], d, m);
  endtask
  task automatic rdx(input int r, input int c, input logic [31:0] e0, input logic [31:0] e1);
    step();
    c_en = 1; c_re = 1; c_row = 2'(r); c_col = 2'(c);
    rq[0].push_back({e0, 32'(cyc + 1)});
    rq[1].push_back({e1, 32'(cyc + 1)});
  endtask
  task automatic rd(input int r, input int c);
    rdx(r, c, mdl[r*4+c], mdl[r*4+c]);
  endtask
  task automatic chk_zero(input string nm);
    for (int g = 0; g < 2; g++) begin
      chk({nm, " port"}, {rdata[g], rvalid[g], clr_done[g], busy[g]}, 0);
      chk({nm, " drain"}, {drn_valid[g], drn_data[g], drn_row[g], drn_col[g], drn_last[g]}, 0);
    end
  endtask
  task automatic push_drain();
    for (int a = 0; a < 16; a++)
      for (int g = 0; g < 2; g++) dq[g].push_back({mdl[a], 2'(a / 4), 2'(a % 4), a == 15});
  endtask
  task automatic run_drain(input bit toggle);
    int i = 0, b0 = nbeat[0], b1 = nbeat[1];
    push_drain();
    step();
    drn_start = 1;
    do begin
      step();
      drn_ready = toggle ? (i % 3 == 0) : 1'b1;
      i++;
    end while (busy[0] && i < 400);
    drn_ready = 1;
    chk("drain timeout", i < 400, 1);
    chk("drain beat count u0", nbeat[0] - b0, 16);
    chk("drain beat count u1", nbeat[1] - b1, 16);
  endtask
  initial begin
    int b, i;
    rst_n = 0; drn_ready = 1;
    c_en = 0; c_re = 0; c_we_en = 0; c_we = 0; clr_start = 0; drn_start = 0;
    c_row = 0; c_col = 0; c_wrow = 0; c_wcol = 0; c_wdata = 0; c_wmask = 0;
    for (int a = 0; a < 16; a++) mdl[a] = 'x;
    repeat (3) @(negedge clk);
    #1 chk_zero("reset");
    rst_n = 1;
    wr(1, 2, 32'hDEADBEEF, 4'hF);
    wr(1, 2, 32'h000000AA, 4'b0001);
    rdx(1, 2, 32'hDEADBEAA, 32'hDEADBEAA);
    wr(1, 2, 32'hFFFFFFFF, 4'h0);
    rdx(1, 2, 32'hDEADBEAA, 32'hDEADBEAA);
    wr(3, 3, 32'h0, 4'hF);
    step();
    c_we_en = 1; c_we = 1; c_wrow = 3; c_wcol = 3; c_wdata = 32'h12345678; c_wmask = 4'hF;
    c_en = 1; c_re = 1; c_row = 3; c_col = 3;
    rq[0].push_back({32'h00000000, 32'(cyc + 1)});
    rq[1].push_back({32'h12345678, 32'(cyc + 1)});
    mdl[15] = 32'h12345678;
    rdx(3, 3, 32'h12345678, 32'h12345678);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wr(r, c, 32'(r * 16 + c), 4'hF);
    b = nbeat[0];
    push_drain();
    step();
    drn_start = 1;
    step();
    #1 chk("drain valid at start+1", drn_valid[0], 0);
    chk("busy in drain", busy[0], 1);
    step();
    #1 chk("drain valid at start+2", drn_valid[0], 1);
    repeat (16) step();
    #1 chk("busy low after 16 beats", busy[0], 0);
    chk("16 consecutive beats", nbeat[0] - b, 16);
    run_drain(1);
    step();
    clr_start = 1;
    for (int a = 0; a < 16; a++) mdl[a] = 0;
    for (int j = 1; j <= 16; j++) begin
      step();
      if (j == 10) begin
        c_we_en = 1; c_we = 1; c_wrow = 0; c_wcol = 0; c_wdata = 32'h5; c_wmask = 4'hF;
        c_en = 1; c_re = 1; c_row = 0; c_col = 0;
      end
      #1 chk("busy during clear", {busy[0], busy[1]}, 2'b11);
      chk("no clr_done during clear", {clr_done[0], clr_done[1]}, 2'b00);
    end
    step();
    #1 chk("busy after clear", {busy[0], busy[1]}, 2'b00);
    chk("clr_done pulse", {clr_done[0], clr_done[1]}, 2'b11);
    step();
    #1 chk("clr_done one cycle", {clr_done[0], clr_done[1]}, 2'b00);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) rd(r, c);
    wr(2, 1, 32'h77, 4'hF);
    step();
    clr_start = 1; drn_start = 1;
    mdl[9] = 0;
    for (int j = 1; j <= 17; j++) begin
      step();
      #1 chk("no drain on joint start", drn_valid[0], 0);
    end
    chk("joint start idle", busy[0], 0);
    rd(2, 1);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wr(r, c, 32'h100 + 32'(r * 16 + c), 4'hF);
    b = nbeat[0];
    i = 0;
    push_drain();
    step();
    drn_start = 1;
    do begin
      step();
      #2 i++;
    end while (nbeat[0] - b < 5 && i < 50);
    chk("reached drain beat 5", nbeat[0] - b, 5);
    rst_n = 0;
    #1 chk_zero("async reset");
    dq[0].delete();
    dq[1].delete();
    step();
    rst_n = 1;
    step();
    #1 chk("busy after reset release", busy[0], 0);
    run_drain(0);
    repeat (3) step();
    chk("read queue u0 empty", rq[0].size(), 0);
    chk("read queue u1 empty", rq[1].size(), 0);
    chk("drain queue empty", dq[0].size() + dq[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
